tx_packet_sequencer: RTL and testbench

TX_PACKET_SEQUENCER -- requirements
Module: tx_packet_sequencer

---
 rtl/tx_packet_sequencer.sv | 147 ++++++++++++++
 tb/tb_tx_packet_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_packet_sequencer.sv
// Transmit packet sequencer: pops bytes from a data buffer and hands them one
// at a time to a TX encoder with a valid/ready handshake, with abort and error reporting.
module tx_packet_sequencer #(
  parameter int MAX_PKT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] packet_size,
  input  logic       abort,
  input  logic [6:0] buffer_occupancy,
  input  logic [7:0] tx_packet_data,
  output logic       get_tx_data,
  output logic       flush,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [6:0] bytes_sent
);

  localparam logic [6:0] MAX_PKT_W = 7'(MAX_PKT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SEND  = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t     state_q;
  logic [6:0] remaining_q;
  logic [6:0] bytes_sent_q;
  logic [7:0] byte_out_q;
  logic       byte_valid_q;
  logic       get_tx_data_q;
  logic       flush_q;
  logic       busy_q;
  logic       done_q;
  logic       err_q;

  logic size_bad_s;
  logic abort_act_s;

  always_comb begin
    size_bad_s  = 1'b0;
    abort_act_s = 1'b0;
    if ((packet_size > MAX_PKT_W) || (buffer_occupancy < packet_size)) begin
      size_bad_s = 1'b1;
    end else begin
      size_bad_s = 1'b0;
    end
    if (abort && (state_q != S_IDLE)) begin
      abort_act_s = 1'b1;
    end else begin
      abort_act_s = 1'b0;
    end
  end

  // Pulse outputs default low each cycle; abort outranks every state action.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      remaining_q   <= 7'd0;
      bytes_sent_q  <= 7'd0;
      byte_out_q    <= 8'h00;
      byte_valid_q  <= 1'b0;
      get_tx_data_q <= 1'b0;
      flush_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      get_tx_data_q <= 1'b0;
      flush_q       <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      if (abort_act_s) begin
        state_q      <= S_IDLE;
        byte_valid_q <= 1'b0;
        flush_q      <= 1'b1;
        busy_q       <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start && !abort) begin
              bytes_sent_q <= 7'd0;
              busy_q       <= 1'b1;
              if (packet_size == 7'd0) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else if (size_bad_s) begin
                state_q <= S_ERR;
                err_q   <= 1'b1;
              end else begin
                remaining_q   <= packet_size;
                state_q       <= S_FETCH;
                get_tx_data_q <= 1'b1;
              end
            end
          end
          S_FETCH: begin
            byte_out_q   <= tx_packet_data;
            byte_valid_q <= 1'b1;
            state_q      <= S_SEND;
          end
          S_SEND: begin
            if (byte_ready) begin
              bytes_sent_q <= bytes_sent_q + 7'd1;
              remaining_q  <= remaining_q - 7'd1;
              byte_valid_q <= 1'b0;
              if (remaining_q == 7'd1) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q       <= S_FETCH;
                get_tx_data_q <= 1'b1;
              end
            end
          end
          S_DONE, S_ERR: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            byte_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign get_tx_data = get_tx_data_q;
  assign flush       = flush_q;
  assign byte_out    = byte_out_q;
  assign byte_valid  = byte_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign bytes_sent  = bytes_sent_q;

endmodule

// File: tb/tb_tx_packet_sequencer.sv
// Scoreboard bench for tx_packet_sequencer: a byte-queue buffer model feeds the DUT,
// the driver predicts bytes and end events, and a negedge monitor compares them.
module tb_tx_packet_sequencer;
  localparam int MAX_PKT = 64;
  localparam int K_DONE = 1, K_ERR = 2, K_FLUSH = 4;

  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, byte_ready = 1'b0;
  logic [6:0] packet_size = 7'd0;
  logic [6:0] buffer_occupancy;
  logic [7:0] tx_packet_data;
  logic       get_tx_data, flush, byte_valid, busy, done, err;
  logic [7:0] byte_out;
  logic [6:0] bytes_sent;

  tx_packet_sequencer #(.MAX_PKT(MAX_PKT)) dut (
    .clk(clk), .rst(rst), .start(start), .packet_size(packet_size), .abort(abort),
    .buffer_occupancy(buffer_occupancy), .tx_packet_data(tx_packet_data),
    .get_tx_data(get_tx_data), .flush(flush), .byte_out(byte_out), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .busy(busy), .done(done), .err(err), .bytes_sent(bytes_sent)
  );

  always #5 clk = ~clk;

  // Data buffer: circular store, popped by get_tx_data, emptied by flush or reset.
  logic [7:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) rd_ptr <= wr_ptr;
    else if (flush) rd_ptr <= wr_ptr;
    else if (get_tx_data) rd_ptr <= rd_ptr + 1;
  end
  assign buffer_occupancy = 7'(wr_ptr - rd_ptr);
  assign tx_packet_data   = mem[8'(rd_ptr)];

  typedef struct { int kind; int bsent; int pops; bit hs_timing; } evt_t;
  evt_t       exp_evt[$];
  logic [7:0] exp_bytes[$];
  logic [7:0] ref_q[$];

  int n_checks = 0, n_pass = 0;
  int pops = 0, hs = 0, cyc = 0, last_hs_cyc = -10, outstanding = 0, flushes = 0;
  bit stalled = 1'b0;
  logic [7:0] held = 8'h00;

  function void check(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endfunction

  // Monitor: samples on the falling edge, between driver updates and DUT edges.
  initial begin
    evt_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
        outstanding = 0;
      end else begin
        cyc++;
        if (stalled) begin
          check("hold_valid", byte_valid, 1);
          check("hold_byte", byte_out, held);
        end
        stalled = byte_valid && !byte_ready && !abort;
        held = byte_out;
        if (get_tx_data) begin
          check("pop_before_handshake", outstanding, 0);
          outstanding = 1;
          pops++;
        end
        if (byte_valid && byte_ready && !abort) begin
          check("hs_after_pop", outstanding, 1);
          outstanding = 0;
          if (exp_bytes.size() == 0) check("byte_unexpected", 1, 0);
          else check("byte_out", byte_out, exp_bytes.pop_front());
          hs++;
          last_hs_cyc = cyc;
        end
        if (flush) flushes++;
        if (done || err || flush) begin
          if (exp_evt.size() == 0) begin
            check("evt_unexpected", {flush, err, done}, 0);
          end else begin
            e = exp_evt.pop_front();
            check("evt_kind", {flush, err, done}, e.kind);
            check("evt_bytes_sent", bytes_sent, e.bsent);
            if (e.kind == K_FLUSH) begin
              check("flush_busy", busy, 0);
              outstanding = 0;
            end else begin
              check("evt_pops", pops, e.pops);
            end
            if (e.hs_timing) check("done_latency", last_hs_cyc, cyc - 1);
          end
        end
      end
    end
  end

  task automatic push_buf(input int n, input int base);
    logic [7:0] v;
    for (int i = 0; i < n; i++) begin
      v = (base < 0) ? 8'($urandom) : 8'(base + i);
      mem[8'(wr_ptr)] = v;
      wr_ptr++;
      ref_q.push_back(v);
    end
  endtask

  task automatic run_pkt(input int size, input int pct, input int abort_after,
                         input bit start_before, input int stall);
    evt_t e;
    int hs0, cnt;
    bit aborted;
    aborted = 1'b0;
    hs0 = hs;
    e.pops = pops;
    e.hs_timing = 1'b0;
    if (size == 0) begin
      e.kind = K_DONE; e.bsent = 0;
    end else if (size > MAX_PKT || ref_q.size() < size) begin
      e.kind = K_ERR; e.bsent = 0;
    end else begin
      e.kind = K_DONE; e.bsent = size; e.pops = pops + size; e.hs_timing = 1'b1;
      repeat (size) exp_bytes.push_back(ref_q.pop_front());
    end
    exp_evt.push_back(e);
    start = 1'b1;
    packet_size = 7'(size);
    byte_ready = ($urandom_range(0, 99) < pct);
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 0;
    while (busy && cnt < 3000) begin
      abort = 1'b0;
      start = 1'b0;
      if (!aborted && abort_after >= 0 && (hs - hs0) == abort_after && !done && !err) begin
        if (start_before) begin
          start = 1'b1; packet_size = 7'd1; byte_ready = 1'b0; start_before = 1'b0;
        end else begin
          abort = 1'b1; byte_ready = 1'b0; aborted = 1'b1;
          exp_bytes.delete(); ref_q.delete(); exp_evt.delete();
          e.kind = K_FLUSH; e.bsent = abort_after; e.pops = 0; e.hs_timing = 1'b0;
          exp_evt.push_back(e);
        end
      end else if (stall > 0 && byte_valid && hs == hs0) begin
        byte_ready = 1'b0;
        stall--;
      end else begin
        byte_ready = ($urandom_range(0, 99) < pct);
      end
      @(posedge clk); #1;
      cnt++;
    end
    abort = 1'b0;
    start = 1'b0;
    byte_ready = 1'b0;
    check("pkt_timeout", int'(cnt < 3000), 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("evt_drained", exp_evt.size(), 0);
    check("bytes_drained", exp_bytes.size(), 0);
  endtask

  initial begin
    int f0, size, pct, ab, r, room;
    #13;
    check("reset_outputs", {get_tx_data, flush, byte_out, byte_valid, busy, done, err, bytes_sent}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", busy, 0);

    push_buf(4, 1);
    run_pkt(4, 100, -1, 1'b0, 0);
    check("normal_bytes_sent", bytes_sent, 4);

    push_buf(2, 1);
    run_pkt(2, 100, -1, 1'b0, 5);

    push_buf(2, -1);
    run_pkt(3, 100, -1, 1'b0, 0);
    run_pkt(65, 100, -1, 1'b0, 0);
    run_pkt(0, 100, -1, 1'b0, 0);

    push_buf(4, 16);
    run_pkt(4, 100, 2, 1'b1, 0);
    check("abort_bytes_sent", bytes_sent, 2);
    check("abort_busy", busy, 0);

    f0 = flushes;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_abort_no_flush", flushes, f0);
    push_buf(2, -1);
    start = 1'b1; abort = 1'b1; packet_size = 7'd1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", busy, 0);
    check("start_abort_no_pop", get_tx_data, 0);
    repeat (3) @(posedge clk);
    #1;
    check("start_abort_no_flush", flushes, f0);

    for (int k = 0; k < 40; k++) begin
      room = 120 - ref_q.size();
      push_buf($urandom_range(0, (room < 30) ? room : 30), -1);
      r = $urandom_range(0, 9);
      if (r == 0) size = 0;
      else if (r == 1) size = $urandom_range(65, 127);
      else if (r == 2) size = ref_q.size() + $urandom_range(1, 5);
      else if (ref_q.size() == 0) size = 0;
      else size = $urandom_range(1, (ref_q.size() < 20) ? ref_q.size() : 20);
      pct = $urandom_range(30, 100);
      ab = -1;
      if (size > 0 && size <= MAX_PKT && size <= ref_q.size() && $urandom_range(0, 4) == 0)
        ab = $urandom_range(0, size - 1);
      run_pkt(size, pct, ab, 1'b0, 0);
    end

    // Reset mid-packet: async assertion between clock edges, no end pulses after.
    push_buf(10, -1);
    repeat (10) exp_bytes.push_back(ref_q.pop_front());
    start = 1'b1; packet_size = 7'd10; byte_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midreset_outputs", {get_tx_data, flush, byte_out, byte_valid, busy, done, err, bytes_sent}, 0);
    exp_bytes.delete(); ref_q.delete(); exp_evt.delete();
    byte_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    f0 = flushes;
    repeat (3) @(posedge clk);
    #1;
    check("post_reset_busy", busy, 0);
    check("post_reset_no_flush", flushes, f0);
    push_buf(3, 64);
    run_pkt(3, 60, -1, 1'b0, 0);
    check("post_reset_bytes_sent", bytes_sent, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
